// File: rtl/sd_card_sector_writer_if.sv
// AHB-Lite slave port plus the sector-write handshake toward sd_card_top.
interface sd_card_sector_writer_if;
  logic        HSEL, HREADY, HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR, HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        sd_init_done;
  logic        sd_sec_write;
  logic [31:0] sd_sec_write_addr;
  logic [7:0]  sd_sec_write_data;
  logic        sd_sec_write_data_req;
  logic        sd_sec_write_end;

  modport slave (
    input  HSEL, HREADY, HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
           sd_init_done, sd_sec_write_data_req, sd_sec_write_end,
    output HREADYOUT, HRDATA, sd_sec_write, sd_sec_write_addr, sd_sec_write_data
  );
  modport master (
    output HSEL, HREADY, HWRITE, HTRANS, HSIZE, HADDR, HWDATA,
           sd_init_done, sd_sec_write_data_req, sd_sec_write_end,
    input  HREADYOUT, HRDATA, sd_sec_write, sd_sec_write_addr, sd_sec_write_data
  );
endinterface

// File: rtl/sd_card_sector_writer.sv
// 512-byte AHB-loadable sector buffer streamed byte-by-byte into the SD core's
// sector-write port on START; status reported through CTRL.
module sd_card_sector_writer #(
  parameter logic [31:0] BASE_ADDR = 32'h4009_0400
) (
  input logic HCLK,
  input logic HRESET,
  sd_card_sector_writer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_READY, S_WRITE} state_t;

  state_t      state;
  logic        dp_vld, dp_wr;
  logic [9:0]  dp_off;
  logic [2:0]  dp_size;
  logic [31:0] write_addr, last_addr;
  logic        done, overrun, abort_f;
  logic [9:0]  wr_cnt;
  logic [3:0][7:0] mem [128];

  logic        xfer, commit, busy, buf_we, wa_we, start_wr;
  logic [3:0]  be;
  logic [3:0][7:0] rd_word;
  logic [31:0] rd_data;
  logic        unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];
  assign bus.HREADYOUT  = 1'b1;
  assign bus.sd_sec_write_addr = last_addr;

  assign xfer     = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                    (bus.HADDR[31:10] == BASE_ADDR[31:10]);
  assign commit   = dp_vld & dp_wr & bus.HREADY;
  assign busy     = (state == S_WRITE);
  assign buf_we   = commit & ~dp_off[9] & ~busy;
  assign wa_we    = commit & (dp_off[9:2] == 8'h80);
  assign start_wr = commit & (dp_off[9:2] == 8'h82) & bus.HWDATA[0];

  always_comb begin
    be = 4'b1111;
    if (dp_size == 3'd0)      be = 4'b0001 << dp_off[1:0];
    else if (dp_size == 3'd1) be = dp_off[1] ? 4'b1100 : 4'b0011;
  end

  // Read mux with byte-lane bypass of a write committing on the same edge.
  always_comb begin
    rd_word = mem[bus.HADDR[8:2]];
    if (buf_we && dp_off[8:2] == bus.HADDR[8:2])
      for (int k = 0; k < 4; k++)
        if (be[k]) rd_word[k] = bus.HWDATA[8*k +: 8];
    rd_data = 32'h0;
    if (!bus.HADDR[9]) rd_data = rd_word;
    else case (bus.HADDR[8:2])
      7'h00:   rd_data = wa_we ? bus.HWDATA : write_addr;
      7'h01:   rd_data = last_addr;
      7'h02:   rd_data = {26'h0, abort_f, overrun, busy, bus.sd_init_done, done, 1'b0};
      default: rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge HCLK)
    if (buf_we)
      for (int k = 0; k < 4; k++)
        if (be[k]) mem[dp_off[8:2]][k] <= bus.HWDATA[8*k +: 8];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state                 <= S_IDLE;
      dp_vld                <= 1'b0;
      dp_wr                 <= 1'b0;
      dp_off                <= '0;
      dp_size               <= '0;
      write_addr            <= '0;
      last_addr             <= '0;
      done                  <= 1'b0;
      overrun               <= 1'b0;
      abort_f               <= 1'b0;
      wr_cnt                <= '0;
      bus.HRDATA            <= '0;
      bus.sd_sec_write      <= 1'b0;
      bus.sd_sec_write_data <= '0;
    end else begin
      if (bus.HREADY) begin
        dp_vld  <= xfer;
        dp_wr   <= bus.HWRITE;
        dp_off  <= bus.HADDR[9:0];
        dp_size <= bus.HSIZE;
      end
      if (xfer && !bus.HWRITE) bus.HRDATA <= rd_data;
      if (wa_we) write_addr <= bus.HWDATA;
      if (commit && !dp_off[9] && busy) overrun <= 1'b1;

      // Past the end of the sector the core is fed zeros and wr_cnt holds at 512.
      if (busy && bus.sd_sec_write_data_req) begin
        bus.sd_sec_write_data <= wr_cnt[9] ? 8'h00 : mem[wr_cnt[8:2]][wr_cnt[1:0]];
        if (!wr_cnt[9]) wr_cnt <= wr_cnt + 10'd1;
      end

      case (state)
        S_IDLE:  if (bus.sd_init_done) state <= S_READY;
        S_READY: if (start_wr) begin
          state            <= S_WRITE;
          done             <= 1'b0;
          overrun          <= 1'b0;
          abort_f          <= 1'b0;
          last_addr        <= write_addr;
          wr_cnt           <= '0;
          bus.sd_sec_write <= 1'b1;
        end
        S_WRITE: if (bus.sd_sec_write_end) begin
          state            <= S_READY;
          done             <= 1'b1;
          bus.sd_sec_write <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      // Losing the card overrides everything, including a same-cycle START.
      if (!bus.sd_init_done) begin
        state            <= S_IDLE;
        bus.sd_sec_write <= 1'b0;
        if (busy) abort_f <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sd_card_sector_writer.sv
// Randomized bench for sd_card_sector_writer against a byte-array buffer model.
module tb_sd_card_sector_writer;
  localparam logic [31:0] BASE = 32'h4009_0400;

  logic HCLK = 1'b0;
  logic HRESET;
  sd_card_sector_writer_if bus();

  sd_card_sector_writer #(.BASE_ADDR(BASE)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  always #5 HCLK = ~HCLK;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int req_idx = 0;
  logic [7:0] ref_buf [512];

  task automatic tick; @(posedge HCLK); #1; endtask

  task automatic bus_idle;
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic [9:0] off, input logic wr, input logic [2:0] sz);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = wr; bus.HSIZE = sz;
    bus.HADDR = BASE + {22'h0, off};
  endtask

  task automatic ahb_write(input logic [9:0] off, input logic [2:0] sz, input logic [31:0] d);
    addr_phase(off, 1'b1, sz); tick;
    bus_idle(); bus.HWDATA = d; tick;
  endtask

  task automatic ahb_read(input logic [9:0] off, output logic [31:0] d);
    addr_phase(off, 1'b0, 3'd2); tick;
    bus_idle(); d = bus.HRDATA;
  endtask

  // Buffer semantics: 1, 2 or 4 bytes at the size-aligned address, each taken from its own lane.
  task automatic model_write(input logic [9:0] off, input logic [2:0] sz, input logic [31:0] d);
    int n, a;
    if (off[9]) return;
    n = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
    a = int'(off[8:0]) / n * n;
    for (int j = 0; j < n; j++) ref_buf[a + j] = d[8 * ((a + j) % 4) +: 8];
  endtask

  function automatic logic [31:0] model_word(input logic [9:0] off);
    int a;
    a = int'(off[8:0]) / 4 * 4;
    return {ref_buf[a+3], ref_buf[a+2], ref_buf[a+1], ref_buf[a]};
  endfunction

  task automatic start_sector;
    ahb_write(10'h208, 3'd2, 32'h1);
    req_idx = 0;
  endtask

  task automatic feed(input int n, input bit end_on_last);
    for (int i = 0; i < n; i++) begin
      logic [7:0] exp;
      exp = (req_idx < 512) ? ref_buf[req_idx] : 8'h00;
      bus.sd_sec_write_data_req = 1'b1;
      if (end_on_last && i == n - 1) bus.sd_sec_write_end = 1'b1;
      tick;
      bus.sd_sec_write_data_req = 1'b0;
      bus.sd_sec_write_end = 1'b0;
      chk_cnt++;
      if (bus.sd_sec_write_data !== exp)
        $display("FAIL data_byte[%0d]: got %h want %h", req_idx, bus.sd_sec_write_data, exp);
      else pass_cnt++;
      req_idx++;
      repeat ($urandom_range(0, 2)) tick;
    end
  endtask

  task automatic test_reset;
    logic [31:0] v;
    tick; tick;
    chk_cnt++;
    if ({bus.HRDATA, bus.sd_sec_write, bus.sd_sec_write_addr, bus.sd_sec_write_data, bus.HREADYOUT} !== {73'h0, 1'b1})
      $display("FAIL reset_outputs: got rd=%h sw=%b sa=%h sd=%h ro=%b want 0/0/0/0/1",
               bus.HRDATA, bus.sd_sec_write, bus.sd_sec_write_addr, bus.sd_sec_write_data, bus.HREADYOUT);
    else pass_cnt++;
    HRESET = 1'b0; tick;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", v); else pass_cnt++;
    ahb_read(10'h200, v);
    chk_cnt++; if (v !== 32'h0) $display("FAIL reset_write_addr: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_buffer_pattern;
    logic [31:0] v, d;
    for (int i = 0; i < 128; i++) begin
      d = i * 32'h0404_0404 + 32'h0302_0100;
      ahb_write(10'(i * 4), 3'd2, d);
      model_write(10'(i * 4), 3'd2, d);
    end
    for (int i = 0; i < 128; i++) begin
      ahb_read(10'(i * 4), v);
      chk_cnt++;
      if (v !== model_word(10'(i * 4))) $display("FAIL pattern_word[%0d]: got %h want %h", i, v, model_word(10'(i * 4)));
      else pass_cnt++;
    end
    ahb_write(10'h005, 3'd0, 32'h0000_AA00);
    model_write(10'h005, 3'd0, 32'h0000_AA00);
    ahb_read(10'h004, v);
    chk_cnt++; if (v !== 32'h0706_AA04) $display("FAIL byte_write_word1: got %h want 07 06 aa 04", v); else pass_cnt++;
    ahb_write(10'h005, 3'd0, 32'h0000_0500);
    model_write(10'h005, 3'd0, 32'h0000_0500);
  endtask

  task automatic test_sector_write;
    logic [31:0] v;
    bus.sd_init_done = 1'b1; tick;
    ahb_write(10'h200, 3'd2, 32'h1234);
    ahb_read(10'h200, v);
    chk_cnt++; if (v !== 32'h1234) $display("FAIL write_addr_rb: got %h want 1234", v); else pass_cnt++;
    start_sector();
    chk_cnt++;
    if (bus.sd_sec_write !== 1'b1 || bus.sd_sec_write_addr !== 32'h1234)
      $display("FAIL start_outputs: got sw=%b sa=%h want 1/1234", bus.sd_sec_write, bus.sd_sec_write_addr);
    else pass_cnt++;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h0C) $display("FAIL ctrl_busy: got %h want 0c", v); else pass_cnt++;
    feed(512, 1'b0);
    bus.sd_sec_write_end = 1'b1; tick; bus.sd_sec_write_end = 1'b0;
    chk_cnt++; if (bus.sd_sec_write !== 1'b0) $display("FAIL end_deassert: got %b want 0", bus.sd_sec_write); else pass_cnt++;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h06) $display("FAIL ctrl_done: got %h want 06", v); else pass_cnt++;
  endtask

  task automatic test_overrun;
    logic [31:0] v;
    start_sector();
    ahb_write(10'h200, 3'd2, 32'h99);
    ahb_write(10'h000, 3'd2, 32'hDEAD_BEEF);
    ahb_read(10'h204, v);
    chk_cnt++; if (v !== 32'h1234) $display("FAIL last_addr_hold: got %h want 1234", v); else pass_cnt++;
    ahb_read(10'h200, v);
    chk_cnt++; if (v !== 32'h99) $display("FAIL write_addr_busy: got %h want 99", v); else pass_cnt++;
    ahb_read(10'h000, v);
    chk_cnt++; if (v !== model_word(10'h000)) $display("FAIL buf_dropped: got %h want %h", v, model_word(10'h000)); else pass_cnt++;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h1C) $display("FAIL ctrl_overrun: got %h want 1c", v); else pass_cnt++;
    feed(512, 1'b1);
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h16) $display("FAIL ctrl_overrun_done: got %h want 16", v); else pass_cnt++;
  endtask

  task automatic test_saturation;
    logic [31:0] v;
    start_sector();
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h0C) $display("FAIL ctrl_restart: got %h want 0c", v); else pass_cnt++;
    chk_cnt++; if (bus.sd_sec_write_addr !== 32'h99) $display("FAIL sec_addr_new: got %h want 99", bus.sd_sec_write_addr); else pass_cnt++;
    feed(520, 1'b1);
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h06) $display("FAIL ctrl_sat_done: got %h want 06", v); else pass_cnt++;
  endtask

  task automatic test_random_buffer;
    logic [31:0] v, d;
    logic [9:0] off;
    logic [2:0] sz;
    for (int i = 0; i < 80; i++) begin
      off = 10'($urandom_range(0, 511)); sz = 3'($urandom_range(0, 3)); d = $urandom;
      ahb_write(off, sz, d);
      model_write(off, sz, d);
    end
    for (int i = 0; i < 40; i++) begin
      off = 10'($urandom_range(0, 511));
      ahb_read(off, v);
      chk_cnt++;
      if (v !== model_word(off)) $display("FAIL rand_read[%h]: got %h want %h", off, v, model_word(off));
      else pass_cnt++;
    end
    ahb_write(10'h20C, 3'd2, $urandom);
    ahb_read(10'h20C, v);
    chk_cnt++; if (v !== 32'h0) $display("FAIL unmapped_20c: got %h want 0", v); else pass_cnt++;
    ahb_read(10'h3F0, v);
    chk_cnt++; if (v !== 32'h0) $display("FAIL unmapped_3f0: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] v, d;
    logic [9:0] off;
    logic [2:0] sz;
    for (int i = 0; i < 24; i++) begin
      off = 10'($urandom_range(0, 511)); sz = 3'($urandom_range(0, 2)); d = $urandom;
      addr_phase(off, 1'b1, sz); tick;
      addr_phase(off, 1'b0, 3'd2); bus.HWDATA = d; tick;
      bus_idle(); v = bus.HRDATA;
      model_write(off, sz, d);
      chk_cnt++;
      if (v !== model_word(off)) $display("FAIL b2b[%h] size %0d: got %h want %h", off, sz, v, model_word(off));
      else pass_cnt++;
    end
    d = $urandom;
    addr_phase(10'h200, 1'b1, 3'd2); tick;
    addr_phase(10'h200, 1'b0, 3'd2); bus.HWDATA = d; tick;
    bus_idle(); v = bus.HRDATA;
    chk_cnt++; if (v !== d) $display("FAIL b2b_write_addr: got %h want %h", v, d); else pass_cnt++;
  endtask

  task automatic test_random_sector;
    logic [31:0] v;
    start_sector();
    feed(512, 1'b1);
    chk_cnt++; if (bus.sd_sec_write !== 1'b0) $display("FAIL end_with_req: got %b want 0", bus.sd_sec_write); else pass_cnt++;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h06) $display("FAIL ctrl_rand_done: got %h want 06", v); else pass_cnt++;
  endtask

  task automatic test_abort;
    logic [31:0] v;
    start_sector();
    feed(7, 1'b0);
    bus.sd_init_done = 1'b0; tick;
    chk_cnt++; if (bus.sd_sec_write !== 1'b0) $display("FAIL abort_deassert: got %b want 0", bus.sd_sec_write); else pass_cnt++;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h20) $display("FAIL ctrl_abort: got %h want 20", v); else pass_cnt++;
    start_sector();
    chk_cnt++; if (bus.sd_sec_write !== 1'b0) $display("FAIL start_in_idle: got %b want 0", bus.sd_sec_write); else pass_cnt++;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h20) $display("FAIL ctrl_idle_start: got %h want 20", v); else pass_cnt++;
    bus.sd_init_done = 1'b1; tick;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h24) $display("FAIL ctrl_init_back: got %h want 24", v); else pass_cnt++;
    start_sector();
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h0C) $display("FAIL ctrl_abort_clear: got %h want 0c", v); else pass_cnt++;
    feed(512, 1'b1);
  endtask

  task automatic test_reset_midwrite;
    logic [31:0] v;
    ahb_write(10'h200, 3'd2, 32'h0BAD_0001);
    start_sector();
    ahb_read(10'h208, v);
    feed(10, 1'b0);
    #3 HRESET = 1'b1;
    #1;
    chk_cnt++;
    if ({bus.HRDATA, bus.sd_sec_write, bus.sd_sec_write_addr, bus.sd_sec_write_data} !== 73'h0)
      $display("FAIL async_reset: got rd=%h sw=%b sa=%h sd=%h want all 0",
               bus.HRDATA, bus.sd_sec_write, bus.sd_sec_write_addr, bus.sd_sec_write_data);
    else pass_cnt++;
    bus.sd_init_done = 1'b0;
    tick; tick;
    HRESET = 1'b0; tick;
    ahb_read(10'h208, v);
    chk_cnt++; if (v !== 32'h0) $display("FAIL ctrl_after_reset: got %h want 0", v); else pass_cnt++;
    ahb_read(10'h200, v);
    chk_cnt++; if (v !== 32'h0) $display("FAIL wa_after_reset: got %h want 0", v); else pass_cnt++;
  endtask

  initial begin
    HRESET = 1'b1;
    bus.HSEL = 1'b0; bus.HREADY = 1'b1; bus.HWRITE = 1'b0; bus.HTRANS = 2'b00;
    bus.HSIZE = 3'd0; bus.HADDR = 32'h0; bus.HWDATA = 32'h0;
    bus.sd_init_done = 1'b0; bus.sd_sec_write_data_req = 1'b0; bus.sd_sec_write_end = 1'b0;
    test_reset();
    test_buffer_pattern();
    test_sector_write();
    test_overrun();
    test_saturation();
    test_random_buffer();
    test_back_to_back();
    test_random_sector();
    test_abort();
    test_reset_midwrite();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
